// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// A configurable wait is inserted between request acceptance and the response.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_write_data,
  input  logic [31:0] i_write_mask,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_read_data,
  output logic        o_err
);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, data_q, mask_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, commit, acc_err, acc_we;
  logic [31:0] acc_addr, acc_data, acc_mask;
  logic [IW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];

  assign o_req_ready = (state == IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;

  // With zero latency the access happens on the acceptance edge itself,
  // so the live request inputs feed the array instead of the captured copy.
  assign acc_addr = (state == IDLE) ? i_addr       : addr_q;
  assign acc_data = (state == IDLE) ? i_write_data : data_q;
  assign acc_mask = (state == IDLE) ? i_write_mask : mask_q;
  assign acc_we   = (state == IDLE) ? i_we         : we_q;
  assign acc_err  = (acc_addr[1:0] != 2'b00) ||
                    ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS);
  assign idx      = acc_addr[IW+1:2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (i_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= i_addr;
        data_q <= i_write_data;
        mask_q <= i_write_mask;
        we_q   <= i_we;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (!acc_err && !acc_we) ? mem[idx] : '0;
      end
    end
  end

  // Array is not reset; commit is never raised while reset holds the FSM in IDLE.
  always_ff @(posedge i_clk) begin
    if (commit && acc_we && !acc_err)
      mem[idx] <= (mem[idx] & ~acc_mask) | (acc_data & acc_mask);
  end

  assign o_resp_valid = (state == RESP);
  assign o_read_data  = o_resp_valid ? rdata_q : '0;
  assign o_err        = o_resp_valid && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b, we, resp_ready;
  logic [31:0] addr, wdata, wmask;
  logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid_a), .o_req_ready(ready_a),
    .i_addr(addr), .i_we(we), .i_write_data(wdata), .i_write_mask(wmask),
    .o_resp_valid(valid_a), .i_resp_ready(resp_ready), .o_read_data(rdata_a), .o_err(err_a)
  );

  mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid_b), .o_req_ready(ready_b),
    .i_addr(addr), .i_we(we), .i_write_data(wdata), .i_write_mask(wmask),
    .o_resp_valid(valid_b), .i_resp_ready(resp_ready), .o_read_data(rdata_b), .o_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One full transaction; lat counts clock edges from acceptance to response valid.
  task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] m, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    we = w; addr = a; wdata = d; wmask = m;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    check("req_ready", sel ? ready_b : ready_a, 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 1;
    while (!(sel ? valid_b : valid_a) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? rdata_b : rdata_a;
    e  = sel ? err_b : err_a;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, c0, n;

    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; we = 1'b0;
    resp_ready = 1'b0; addr = '0; wdata = '0; wmask = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready_a, 32'd0);
    check("rst_valid", valid_a, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_err",   err_a,   32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("ready_after_rst", ready_a, 32'd1);

    // Write then read, latency and throughput
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, rd, e, lat);
    c0 = acc_cyc;
    check("wr_lat", lat, 32'd3);
    check("wr_rdata", rd, 32'd0);
    check("wr_err", e, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, 32'h0, rd, e, lat);
    check("rd_lat", lat, 32'd3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", e, 32'd0);
    check("period", acc_cyc - c0, 32'd4);

    // Partial and zero-mask writes
    access(0, 1'b1, 32'h10, 32'h11223344, 32'hFFFFFFFF, rd, e, lat);
    access(0, 1'b1, 32'h10, 32'h0000AB00, 32'h0000FF00, rd, e, lat);
    access(0, 1'b0, 32'h10, 32'h0, 32'h0, rd, e, lat);
    check("partial", rd, 32'h1122AB44);
    access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 32'h0, rd, e, lat);
    check("zmask_err", e, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, 32'h0, rd, e, lat);
    check("zmask_keep", rd, 32'h1122AB44);

    // Error cases
    access(0, 1'b0, 32'h13, 32'h0, 32'h0, rd, e, lat);
    check("misal_err", e, 32'd1);
    check("misal_data", rd, 32'd0);
    access(0, 1'b1, 32'h0, 32'h01234567, 32'hFFFFFFFF, rd, e, lat);
    access(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, e, lat);
    check("oor_err", e, 32'd1);
    check("oor_data", rd, 32'd0);
    access(0, 1'b0, 32'h0, 32'h0, 32'h0, rd, e, lat);
    check("oor_word0", rd, 32'h01234567);
    check("oor_word0_err", e, 32'd0);

    // Backpressure; a pending request to word 0 is held throughout
    @(negedge clk); req_valid_a = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    addr = 32'h0;
    n = 0;
    while (!valid_a && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_data0", rdata_a, 32'h1122AB44);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", valid_a, 32'd1);
      check("bp_data", rdata_a, 32'h1122AB44);
      check("bp_ready", ready_a, 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    check("bp_post_valid", valid_a, 32'd0);
    check("bp_post_ready", ready_a, 32'd1);
    @(posedge clk); #1; req_valid_a = 1'b0;
    check("bp_accepted", ready_a, 32'd0);
    n = 1;
    while (!valid_a && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_next_lat", n, 32'd3);
    check("bp_next_data", rdata_a, 32'h01234567);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;

    // Reset during WAIT drops the write
    access(0, 1'b1, 32'h20, 32'h5555AAAA, 32'hFFFFFFFF, rd, e, lat);
    @(negedge clk); req_valid_a = 1'b1; we = 1'b1; addr = 32'h20;
    wdata = 32'hCAFEF00D; wmask = 32'hFFFFFFFF;
    @(posedge clk); #1; req_valid_a = 1'b0;
    check("wait_ready", ready_a, 32'd0);
    #2 rst = 1'b1; #1;
    check("rstw_ready", ready_a, 32'd0);
    check("rstw_valid", valid_a, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rstw_ready_after", ready_a, 32'd1);
    access(0, 1'b0, 32'h20, 32'h0, 32'h0, rd, e, lat);
    check("rstw_keep", rd, 32'h5555AAAA);

    // Reset during RESP clears outputs at once
    @(negedge clk); req_valid_a = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk); #1; req_valid_a = 1'b0;
    n = 0;
    while (!valid_a && n < 20) begin @(posedge clk); #1; n++; end
    check("resp_before_rst", rdata_a, 32'h1122AB44);
    #2 rst = 1'b1; #1;
    check("rstr_valid", valid_a, 32'd0);
    check("rstr_data", rdata_a, 32'd0);
    check("rstr_err", err_a, 32'd0);
    @(negedge clk); rst = 1'b0;

    // LATENCY = 0 instance
    access(1, 1'b1, 32'h8, 32'hA5A5A5A5, 32'hFFFFFFFF, rd, e, lat);
    c0 = acc_cyc;
    check("l0_wr_lat", lat, 32'd1);
    access(1, 1'b0, 32'h8, 32'h0, 32'h0, rd, e, lat);
    check("l0_rd_lat", lat, 32'd1);
    check("l0_rd_data", rd, 32'hA5A5A5A5);
    check("l0_period", acc_cyc - c0, 32'd2);
    access(1, 1'b0, 32'h40, 32'h0, 32'h0, rd, e, lat);
    check("l0_oor_err", e, 32'd1);
    check("l0_oor_data", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the internal array (power of two, ≥ 4).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles inserted between request acceptance and response (0..15).
REQ-003 Port i_clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  is the reset: asynchronous, active-high.
REQ-005 Port i_req_valid  input  1  marks a request presented by the initiator.
REQ-006 Port o_req_ready  output  1  marks that the responder accepts a request this cycle.
REQ-007 Port i_addr  input  32  is the byte address of the access.
REQ-008 Port i_we  input  1  selects the access type: 1 = write, 0 = read.
REQ-009 Port i_write_data  input  32  carries the write data, already lane-aligned by the initiator.
REQ-010 Port i_write_mask  input  32  is the per-bit write enable: 1 = bit written.
REQ-011 Port o_resp_valid  output  1  marks that a response is presented.
REQ-012 Port i_resp_ready  input  1  marks that the initiator accepts the response.
REQ-013 Port o_read_data  output  32  carries the read response data.
REQ-014 Port o_err  output  1  flags a request that is out of range or misaligned; valid with o_resp_valid.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, and SHALL occupy exactly one of them at any time.
REQ-016 o_req_ready SHALL be 1 only in IDLE, so at most one request is outstanding.
REQ-017 IDLE: when i_req_valid && o_req_ready, the block SHALL capture addr, we, data and mask, load the wait counter with LATENCY, and go to WAIT (LATENCY > 0) or go to RESP directly (LATENCY = 0).
REQ-018 WAIT: the counter SHALL decrement once per cycle, and the block SHALL go to RESP on the edge where the counter equals 1.
REQ-019 The access SHALL be performed on the edge that enters RESP, so o_resp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 Word index SHALL be addr[31:2]; a request is in error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-021 A valid write SHALL update the array as mem[idx] <= (mem[idx] & ~mask) | (data & mask), and SHALL return o_read_data = 0, o_err = 0.
REQ-022 A valid read SHALL return o_read_data = mem[idx] as held before that edge, with o_err = 0.
REQ-023 An erroneous request SHALL leave the array unmodified and SHALL return o_read_data = 0, o_err = 1.
REQ-024 RESP: o_resp_valid, o_read_data and o_err SHALL stay stable until i_resp_ready = 1; on that handshake edge the block SHALL go to IDLE.
REQ-025 Peak throughput SHALL be one access per LATENCY+2 cycles.
REQ-026 Outside RESP, o_resp_valid SHALL be 0 and o_read_data and o_err SHALL be 0.
REQ-027 Request inputs SHALL be ignored in WAIT and RESP.
REQ-028 A mask of all zeros on a write SHALL be a legal no-op that still produces a response.

Reset
REQ-029 Asserting i_rst SHALL immediately force IDLE, counter = 0, o_req_ready = 1 after release, o_resp_valid = 0, o_read_data = 0 and o_err = 0.
REQ-030 A request in WAIT when i_rst asserts SHALL be dropped and SHALL never commit its write.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 While i_rst is high, o_req_ready SHALL be 0.

Verification
REQ-033 Write followed by read, LATENCY = 2: write addr 0x10, data 0xDEADBEEF, mask 0xFFFFFFFF, then read 0x10 -> each response arrives 3 cycles after acceptance; read returns 0xDEADBEEF with o_err = 0.
REQ-034 Partial write: mem[4] = 0x11223344, write addr 0x10, data 0x0000AB00, mask 0x0000FF00 -> a subsequent read of 0x10 returns 0x1122AB44.
REQ-035 Error cases: read addr 0x13 -> o_err = 1, data 0; write addr DEPTH_WORDS*4 -> o_err = 1, and re-reading word 0 is unchanged.
REQ-036 Response backpressure: hold i_resp_ready = 0 for 5 cycles -> o_resp_valid and o_read_data stay stable and o_req_ready stays 0; a new request is accepted the cycle after the handshake.
REQ-037 Reset mid-operation: assert i_rst in WAIT of a write of 0xCAFEF00D to 0x20 -> outputs clear immediately; after release, a read of 0x20 returns its prior value.
REQ-038 LATENCY = 0 build: a read is accepted at cycle T -> o_resp_valid = 1 in cycle T+1.
